// File: rtl/vcpu32_mem_ctrl_pkg.sv
// Shared VCPU-32 memory-controller definitions: word width, default block size
// and controller state encodings.
package vcpu32_mem_ctrl_pkg;

    localparam int VCPU32_WORD_WIDTH  = 32;
    localparam int VCPU32_BLOCK_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RBEAT = 3'd2,
        ST_WBEAT = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } mem_state_e;

    function automatic mem_state_e beat_state(input logic wr);
        return wr ? ST_WBEAT : ST_RBEAT;
    endfunction

endpackage

// File: rtl/vcpu32_mem_ctrl_if.sv
// Request / beat bus between the VCPU-32 cache miss path (master) and the
// block memory controller (slave).
interface vcpu32_mem_ctrl_if
    import vcpu32_mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = VCPU32_WORD_WIDTH,
    parameter int ADR_WIDTH  = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADR_WIDTH-1:0]  req_adr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  done;
    logic                  err;

    modport master (
        output req_valid, req_wr, req_adr, wdata, wdata_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, done, err
    );

    modport slave (
        input  req_valid, req_wr, req_adr, wdata, wdata_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, done, err
    );
endinterface

// File: rtl/vcpu32_mem_array.sv
// Single-port synchronous word RAM with write enable and registered read data.
// Contents are deliberately not reset.
module vcpu32_mem_array
    import vcpu32_mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = VCPU32_WORD_WIDTH,
    parameter int MEM_WORDS  = 4096,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] q
);
    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end
endmodule

// File: rtl/vcpu32_mem_ctrl.sv
// Block-transfer memory controller: latency wait, then critical-word-first
// beats wrapping within the block against vcpu32_mem_array.
//   IDLE  | ready for a request       WAIT  | latency countdown
//   RBEAT | read beats issued         WBEAT | write beats taken (first cycle primes wdata_ready)
//   DONE  | done pulse next cycle     ERR   | err pulse next cycle
module vcpu32_mem_ctrl
    import vcpu32_mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH  = VCPU32_WORD_WIDTH,
    parameter int ADR_WIDTH   = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int BLOCK_WORDS = VCPU32_BLOCK_WORDS,
    parameter int LATENCY     = 3
) (
    input  logic             clk,
    input  logic             rst,
    vcpu32_mem_ctrl_if.slave bus
);
    localparam int              AW        = $clog2(MEM_WORDS);
    localparam int              OW        = $clog2(BLOCK_WORDS);
    localparam int              IW        = ADR_WIDTH - 2;
    localparam logic [3:0]      LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [OW-1:0]   LAST_BEAT = OW'(BLOCK_WORDS - 1);

    mem_state_e            state;
    logic                  wr_q;
    logic [AW-OW-1:0]      base;
    logic [OW-1:0]         start;
    logic [OW-1:0]         beat_cnt;
    logic [OW-1:0]         off_cur;
    logic [OW-1:0]         off_nxt;
    logic [3:0]            lat_cnt;
    logic                  wready_q;
    logic                  rvalid_q;
    logic                  done_q;
    logic                  err_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic [WORD_WIDTH-1:0] ram_q;
    logic [IW-1:0]         req_idx;
    logic [AW-1:0]         ram_addr;
    logic                  ram_we;
    logic                  unused_adr;

    assign req_idx    = bus.req_adr[ADR_WIDTH-1:2];
    assign unused_adr = ^bus.req_adr[1:0];
    assign off_cur    = start + beat_cnt;
    assign off_nxt    = off_cur + OW'(1);
    assign ram_we     = (state == ST_WBEAT) && wready_q && bus.wdata_valid;

    // The read address runs one beat ahead of rdata: the RAM output and the
    // rdata register each add a cycle.
    always_comb begin
        ram_addr = req_idx[AW-1:0];
        case (state)
            ST_WAIT:  ram_addr = {base, start};
            ST_RBEAT: ram_addr = {base, off_nxt};
            ST_WBEAT: ram_addr = {base, off_cur};
            default:  ram_addr = req_idx[AW-1:0];
        endcase
    end

    vcpu32_mem_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.wdata),
        .q     (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wr_q     <= 1'b0;
            base     <= '0;
            start    <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= (state == ST_RBEAT);
            done_q   <= (state == ST_DONE);
            err_q    <= (state == ST_ERR);
            if (state == ST_RBEAT) begin
                rdata_q <= ram_q;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q     <= bus.req_wr;
                        base     <= req_idx[AW-1:OW];
                        start    <= req_idx[OW-1:0];
                        beat_cnt <= '0;
                        if (req_idx >= IW'(MEM_WORDS)) begin
                            state <= ST_ERR;
                        end else if (LATENCY == 0) begin
                            state <= beat_state(bus.req_wr);
                        end else begin
                            state   <= ST_WAIT;
                            lat_cnt <= LAT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= beat_state(wr_q);
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_RBEAT: begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        beat_cnt <= beat_cnt + OW'(1);
                    end
                end
                ST_WBEAT: begin
                    if (!wready_q) begin
                        wready_q <= 1'b1;
                    end else if (bus.wdata_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            wready_q <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + OW'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.wdata_ready = wready_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_vcpu32_mem_ctrl.sv
// Directed bench for vcpu32_mem_ctrl: a LATENCY=3 instance and a LATENCY=0
// instance, driven one transaction at a time with cycle-exact expectations.
module tb_vcpu32_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_adr;
    logic [31:0] wdata;
    logic        wdata_valid;

    vcpu32_mem_ctrl_if #(.WORD_WIDTH(32), .ADR_WIDTH(32)) bus3 ();
    vcpu32_mem_ctrl_if #(.WORD_WIDTH(32), .ADR_WIDTH(32)) bus0 ();

    assign bus3.req_valid   = req_valid & ~sel;
    assign bus3.req_wr      = req_wr;
    assign bus3.req_adr     = req_adr;
    assign bus3.wdata       = wdata;
    assign bus3.wdata_valid = wdata_valid & ~sel;
    assign bus0.req_valid   = req_valid & sel;
    assign bus0.req_wr      = req_wr;
    assign bus0.req_adr     = req_adr;
    assign bus0.wdata       = wdata;
    assign bus0.wdata_valid = wdata_valid & sel;

    vcpu32_mem_ctrl #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst_n), .bus(bus3));
    vcpu32_mem_ctrl #(.LATENCY(0)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0));

    logic        m_ready, m_wready, m_rv, m_done, m_err;
    logic [31:0] m_rdata;
    assign m_ready  = sel ? bus0.req_ready   : bus3.req_ready;
    assign m_wready = sel ? bus0.wdata_ready : bus3.wdata_ready;
    assign m_rv     = sel ? bus0.rdata_valid : bus3.rdata_valid;
    assign m_rdata  = sel ? bus0.rdata       : bus3.rdata;
    assign m_done   = sel ? bus0.done        : bus3.done;
    assign m_err    = sel ? bus0.err         : bus3.err;

    typedef struct {
        logic             sel;
        logic             wr;
        logic [31:0]      adr;
        logic [3:0][31:0] data;
        logic             exp_err;
        int               stall_at;
        int               poke_n;
    } txn_t;

    txn_t vec[13];
    int checks = 0;
    int errors = 0;

    function automatic txn_t mk(input logic s, input logic w, input logic [31:0] a,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic e, input int stall_at, input int poke_n);
        txn_t t;
        t.sel = s; t.wr = w; t.adr = a; t.data = {d3, d2, d1, d0};
        t.exp_err = e; t.stall_at = stall_at; t.poke_n = poke_n;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input txn_t t, input int id);
        int   lat, beats, stall_left, last_w, done_n, exp_done_n;
        bit   stalled;
        logic exp_rv, exp_wr, exp_done, exp_err;
        lat = t.sel ? 0 : 3;
        beats = 0; stall_left = 0; last_w = -1; done_n = -1; stalled = 0;
        @(negedge clk);
        sel = t.sel;
        #1;
        chk($sformatf("v%0d req_ready before", id), 32'(m_ready), 32'd1);
        req_wr = t.wr; req_adr = t.adr; req_valid = 1'b1; wdata_valid = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            exp_rv   = !t.exp_err && !t.wr && n >= lat + 1 && n <= lat + 4;
            exp_wr   = !t.exp_err && t.wr && n >= lat + 1 && beats < 4;
            exp_done = t.exp_err ? 1'b0 :
                       (t.wr ? (last_w >= 0 && n == last_w + 2) : (n == lat + 5));
            exp_err  = t.exp_err && n == 1;
            chk($sformatf("v%0d n%0d rdata_valid", id, n), 32'(m_rv), 32'(exp_rv));
            chk($sformatf("v%0d n%0d wdata_ready", id, n), 32'(m_wready), 32'(exp_wr));
            chk($sformatf("v%0d n%0d done", id, n), 32'(m_done), 32'(exp_done));
            chk($sformatf("v%0d n%0d err", id, n), 32'(m_err), 32'(exp_err));
            if (exp_rv) begin
                chk($sformatf("v%0d n%0d rdata", id, n), m_rdata, t.data[n - lat - 1]);
            end
            if (m_done && done_n < 0) done_n = n;
            if (t.wr && t.stall_at >= 0 && !stalled && beats == t.stall_at) begin
                stall_left = 2;
                stalled    = 1;
            end
            if (stall_left > 0) begin
                wdata_valid = 1'b0;
                stall_left--;
            end else begin
                wdata_valid = t.wr && beats < 4;
            end
            wdata = (beats < 4) ? t.data[beats] : 32'h0;
            if (exp_wr && wdata_valid) begin
                beats++;
                if (beats == 4) last_w = n;
            end
            req_valid = (n == t.poke_n);
            if (n == t.poke_n) begin
                req_wr  = 1'b0;
                req_adr = 32'h0000_4000;
            end
        end
        req_valid   = 1'b0;
        wdata_valid = 1'b0;
        exp_done_n = t.exp_err ? -1 :
                     (t.wr ? lat + 6 + ((t.stall_at >= 0) ? 2 : 0) : lat + 5);
        chk($sformatf("v%0d done cycle", id), 32'(done_n), 32'(exp_done_n));
        chk($sformatf("v%0d req_ready after", id), 32'(m_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec[0]  = mk(0, 1, 32'h0000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, -1, -1);
        vec[1]  = mk(0, 0, 32'h0000_0108, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 0, -1, -1);
        vec[2]  = mk(0, 0, 32'h0000_4000, 32'h0,  32'h0,  32'h0,  32'h0,  1, -1, -1);
        vec[3]  = mk(0, 1, 32'h0000_020C, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, -1, -1);
        vec[4]  = mk(0, 0, 32'h0000_0200, 32'hB1, 32'hB2, 32'hB3, 32'hB0, 0, -1, -1);
        vec[5]  = mk(0, 1, 32'h0000_0300, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 0,  2, -1);
        vec[6]  = mk(0, 0, 32'h0000_0302, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 0, -1,  1);
        vec[7]  = mk(0, 1, 32'h0000_3FF8, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 0, -1, -1);
        vec[8]  = mk(0, 0, 32'h0000_3FFC, 32'hC1, 32'hC2, 32'hC3, 32'hC0, 0, -1, -1);
        vec[9]  = mk(0, 0, 32'hFFFF_FFFC, 32'h0,  32'h0,  32'h0,  32'h0,  1, -1, -1);
        vec[10] = mk(1, 1, 32'h0000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, -1, -1);
        vec[11] = mk(1, 0, 32'h0000_010C, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 0, -1, -1);
        vec[12] = mk(0, 0, 32'h0000_0108, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 0, -1, -1);

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
        req_adr = 32'h0; wdata = 32'h0; wdata_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready L3", 32'(bus3.req_ready), 32'd1);
        chk("reset wdata_ready L3", 32'(bus3.wdata_ready), 32'd0);
        chk("reset rdata_valid L3", 32'(bus3.rdata_valid), 32'd0);
        chk("reset rdata L3", bus3.rdata, 32'h0);
        chk("reset done L3", 32'(bus3.done), 32'd0);
        chk("reset err L3", 32'(bus3.err), 32'd0);
        chk("reset req_ready L0", 32'(bus0.req_ready), 32'd1);
        chk("reset rdata_valid L0", 32'(bus0.rdata_valid), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(vec[i], i);
        end

        // Reset during the third read beat, then re-read the untouched block.
        @(negedge clk);
        sel = 1'b0;
        #1;
        req_wr = 1'b0; req_adr = 32'h0000_0108; req_valid = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("midreset beat2 valid", 32'(bus3.rdata_valid), 32'd1);
        chk("midreset beat2 data", bus3.rdata, 32'hA0);
        rst_n = 1'b0;
        #1;
        chk("midreset rdata_valid", 32'(bus3.rdata_valid), 32'd0);
        chk("midreset rdata", bus3.rdata, 32'h0);
        chk("midreset done", 32'(bus3.done), 32'd0);
        chk("midreset err", 32'(bus3.err), 32'd0);
        chk("midreset wdata_ready", 32'(bus3.wdata_ready), 32'd0);
        chk("midreset req_ready", 32'(bus3.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("postreset n%0d done", n), 32'(bus3.done), 32'd0);
        end
        run_txn(vec[12], 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
